// File: rtl/bft_leaf_inject_arb.sv
// bft_leaf_inject_arb
//   Leaf-side injection scheduler. Shares one leaf's upward packet bus among num_req local
//   producers using round-robin arbitration, with each requester gated by a token-bucket
//   rate limiter so no single producer can flood the bufferless fabric.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   req_valid    per-requester packet present
//   req_addr     per-requester destination address, requester i at [i*aw +: aw]
//   req_payload  per-requester payload, requester i at [i*payload_sz +: payload_sz]
//   req_ready    combinational one-hot accept
//   inject_en    upward slot available this cycle
//   bus_o        registered packet to the level-0 switch: {valid, addr, payload}
//   grant_o      registered one-hot copy of the accepted requester
module bft_leaf_inject_arb #(
  parameter int unsigned num_leaves = 2,
  parameter int unsigned payload_sz = 1,
  parameter int unsigned num_req    = 4,
  parameter int unsigned tok_max    = 4,
  parameter int unsigned tok_period = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [num_req-1:0]                       req_valid,
  input  logic [num_req*$clog2(num_leaves)-1:0]    req_addr,
  input  logic [num_req*payload_sz-1:0]            req_payload,
  output logic [num_req-1:0]                       req_ready,
  input  logic                                     inject_en,
  output logic [$clog2(num_leaves)+payload_sz:0]   bus_o,
  output logic [num_req-1:0]                       grant_o
);

  localparam int unsigned aw = $clog2(num_leaves);
  localparam int unsigned tw = $clog2(tok_max + 1);
  localparam int unsigned rw = $clog2(num_req);
  localparam int unsigned cw = (tok_period > 1) ? $clog2(tok_period) : 1;

  logic [tw-1:0]      tokens   [num_req];
  logic [tw-1:0]      tok_next [num_req];
  logic [rw-1:0]      rr_ptr;
  logic [cw-1:0]      refill_cnt;
  logic               refill;
  logic [num_req-1:0] eligible;
  logic               found;
  logic [rw-1:0]      win;
  logic               accept;

  assign refill = (refill_cnt == cw'(tok_period - 1));

  always_comb begin
    for (int i = 0; i < num_req; i++) begin
      eligible[i] = req_valid[i] && (tokens[i] != '0);
    end
  end

  // Rotating priority scan starting at rr_ptr; first eligible index wins.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < num_req; k++) begin
      idx = (32'(rr_ptr) + k) % num_req;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx[rw-1:0];
      end
    end
  end

  // Gated by reset so no handshake completes while state is being cleared.
  always_comb begin
    req_ready = '0;
    if (!reset && inject_en && found) begin
      req_ready[win] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Refill before consume; a saturated bucket ignores the refill.
  always_comb begin
    for (int i = 0; i < num_req; i++) begin
      tok_next[i] = tokens[i];
      if (refill && (tokens[i] != tw'(tok_max))) begin
        tok_next[i] = tok_next[i] + 1'b1;
      end
      if (accept && (win == rw'(i))) begin
        tok_next[i] = tok_next[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_o      <= '0;
      grant_o    <= '0;
      rr_ptr     <= '0;
      refill_cnt <= '0;
      for (int i = 0; i < num_req; i++) begin
        tokens[i] <= tw'(tok_max);
      end
    end else begin
      refill_cnt <= refill ? '0 : refill_cnt + 1'b1;
      if (accept) begin
        bus_o   <= {1'b1, req_addr[win*aw +: aw], req_payload[win*payload_sz +: payload_sz]};
        grant_o <= req_ready;
        rr_ptr  <= (win == rw'(num_req - 1)) ? '0 : win + 1'b1;
      end else begin
        // Idle slot drives an all-zero bus, not just a cleared valid bit.
        bus_o   <= '0;
        grant_o <= '0;
      end
      for (int i = 0; i < num_req; i++) begin
        tokens[i] <= tok_next[i];
      end
    end
  end

endmodule
